// File: rtl/proj_kmer_unpacker.sv
// Unpacks KMER_LEN-symbol packed words into a one-symbol-per-cycle valid/ready stream, then pulses start_over after a sequence's final symbol.
// Latency: first symbol valid one cycle after word acceptance; back-to-back words stream with no bubble.
// Backpressure: out_ready=0 holds out_data/out_valid. Optional consumed-symbol counter under PROJ_UNPACK_SYMCNT_EN.
module proj_kmer_unpacker #(
    parameter int DATA_BITS = 2,
    parameter int KMER_LEN  = 16,
    parameter int WORD_BITS = KMER_LEN * DATA_BITS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_BITS-1:0]          in_word,
    input  logic                          in_valid,
    input  logic                          in_last,
    input  logic [$clog2(KMER_LEN):0]     in_count,
    output logic                          in_ready,
    output logic [DATA_BITS-1:0]          out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef PROJ_UNPACK_SYMCNT_EN
    output logic [31:0]                   sym_count,
`endif
    output logic                          start_over
);

    localparam int CW = $clog2(KMER_LEN) + 1;
    localparam logic [CW-1:0] KLEN = CW'(KMER_LEN);
    localparam logic [CW-1:0] ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WORD_BITS-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        rem_q, rem_d;
    logic                 last_q, last_d;
    logic [CW-1:0]        load_cnt;
    logic                 last_sym;
    logic                 accept;
    logic                 consume;

    // Out-of-range counts on a final word fall back to a full word.
    always_comb begin
        load_cnt = KLEN;
        if (in_last && (in_count != '0) && (in_count <= KLEN)) begin
            load_cnt = in_count;
        end
    end

    assign last_sym  = (rem_q <= ONE);
    assign out_valid = (state_q == SHIFT);
    assign out_data  = shreg_q[DATA_BITS-1:0];
    assign start_over = (state_q == FLUSH);
    assign consume   = out_valid && out_ready;
    // Mid-sequence refill window: final symbol of a non-final word leaving now.
    assign in_ready  = !rst && ((state_q == IDLE) ||
                       ((state_q == SHIFT) && !last_q && last_sym && out_ready));
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        rem_d   = rem_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d = in_word;
                    rem_d   = load_cnt;
                    last_d  = in_last;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (out_ready) begin
                    shreg_d = shreg_q >> DATA_BITS;
                    rem_d   = rem_q - ONE;
                    if (last_sym) begin
                        rem_d = '0;
                        if (last_q) begin
                            state_d = FLUSH;
                        end else if (accept) begin
                            shreg_d = in_word;
                            rem_d   = load_cnt;
                            last_d  = in_last;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            FLUSH: begin
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            rem_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
        end
    end

`ifdef PROJ_UNPACK_SYMCNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == FLUSH) begin
            cnt_d = '0;
        end else if (consume) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sym_count = cnt_q;
`else
    logic unused_consume;
    assign unused_consume = consume;
`endif

endmodule
